fir_mac_stream: RTL and testbench

//  Parametrised, streaming signed FIR filter with run-time loadable coefficients.

---
 rtl/fir_mac_stream.sv | 148 ++++++++++++++
 tb/tb_fir_mac_stream.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_stream.sv
// Streaming signed FIR filter that time-multiplexes one multiplier across all taps.
// Ready/valid on both sides, run-time loadable coefficients, saturating output.
module fir_mac_stream #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 4,
    parameter int OUT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_idx,
    input  logic [COEF_W-1:0]       coef_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic                    coef_err
);
    localparam int IDX_W  = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
    localparam int WIDE_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam longint MAX_V = (longint'(1) <<< (OUT_W - 1)) - 1;
    localparam longint MIN_V = -(longint'(1) <<< (OUT_W - 1));
    localparam logic signed [WIDE_W-1:0] SAT_MAX = WIDE_W'(MAX_V);
    localparam logic signed [WIDE_W-1:0] SAT_MIN = WIDE_W'(MIN_V);
    localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(TAPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t state, state_next;

    logic signed [DATA_W-1:0] x [TAPS];
    logic signed [COEF_W-1:0] c [TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [PROD_W-1:0] prod;
    logic signed [WIDE_W-1:0] sum_wide;
    logic signed [OUT_W-1:0]  sat;
    logic [IDX_W-1:0]         tap;
    logic                     idx_ok;
    logic                     accept;

    assign idx_ok = (int'(coef_idx) < TAPS);
    assign accept = in_valid && in_ready;

    always_comb begin
        prod     = c[tap] * x[tap];
        acc_sum  = acc + ACC_W'(prod);
        sum_wide = WIDE_W'(acc_sum);
        if (sum_wide > SAT_MAX) begin
            sat = OUT_W'(SAT_MAX);
        end else if (sum_wide < SAT_MIN) begin
            sat = OUT_W'(SAT_MIN);
        end else begin
            sat = OUT_W'(sum_wide);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !coef_we;
                if (!coef_we && in_valid) begin
                    state_next = MAC;
                end
            end
            MAC: begin
                if (tap == LAST_TAP) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                x[i] <= '0;
                c[i] <= '0;
            end
            c[0]      <= COEF_W'(1);
            acc       <= '0;
            tap       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            coef_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (coef_we) begin
                        if (idx_ok) begin
                            c[coef_idx] <= coef_data;
                        end
                    end else if (accept) begin
                        x[0] <= in_data;
                        for (int unsigned i = 1; i < TAPS; i++) begin
                            x[i] <= x[i-1];
                        end
                        acc <= '0;
                        tap <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_sum;
                    tap <= tap + 1'b1;
                    if (tap == LAST_TAP) begin
                        out_data  <= sat;
                        out_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
            // Writes while busy are dropped; only an in-range index flags the error.
            if (coef_we && idx_ok && (state != IDLE)) begin
                coef_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fir_mac_stream.sv
// Scoreboard bench for fir_mac_stream: a behavioural FIR model pushes expected
// outputs on each accepted sample; they are popped when the core presents a result.
module tb_fir_mac_stream;
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int TAPS   = 4;
    localparam int OUT_W  = 16;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_data = '0;
    logic                    coef_we = 1'b0;
    logic [$clog2(TAPS)-1:0] coef_idx = '0;
    logic [COEF_W-1:0]       coef_data = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [OUT_W-1:0]        out_data;
    logic                    coef_err;

    int checks = 0;
    int failures = 0;

    longint exp_q[$];
    longint mc[TAPS];
    longint mx[TAPS];

    fir_mac_stream #(
        .DATA_W(DATA_W),
        .COEF_W(COEF_W),
        .TAPS  (TAPS),
        .OUT_W (OUT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .coef_we  (coef_we),
        .coef_idx (coef_idx),
        .coef_data(coef_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .coef_err (coef_err)
    );

    always #5 clk = ~clk;

    function automatic longint model_out();
        longint s = 0;
        longint max_v = (longint'(1) <<< (OUT_W - 1)) - 1;
        longint min_v = -(longint'(1) <<< (OUT_W - 1));
        for (int i = 0; i < TAPS; i++) s += mc[i] * mx[i];
        if (s > max_v) s = max_v;
        if (s < min_v) s = min_v;
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < TAPS; i++) begin
            mc[i] = 0;
            mx[i] = 0;
        end
        mc[0] = 1;
        exp_q.delete();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        coef_we = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic coef_write(input int idx, input longint val);
        longint v = val;
        coef_we = 1'b1;
        coef_idx = idx[$clog2(TAPS)-1:0];
        coef_data = v[COEF_W-1:0];
        @(posedge clk);
        #1 coef_we = 1'b0;
        mc[idx] = val;
    endtask

    task automatic send_sample(input longint d);
        longint v = d;
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
            return;
        end
        in_valid = 1'b1;
        in_data = v[DATA_W-1:0];
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = d;
        exp_q.push_back(model_out());
    endtask

    task automatic wait_out(input int elapsed);
        int n = elapsed;
        bit leaked = 1'b0;
        while (!out_valid && n < 50) begin
            if (in_ready) leaked = 1'b1;
            @(posedge clk);
            #1 n++;
        end
        checks++;
        if (n !== TAPS) begin
            failures++;
            $display("FAIL latency: got %0d cycles required %0d", n, TAPS);
        end
        checks++;
        if (leaked !== 1'b0) begin
            failures++;
            $display("FAIL busy_in_ready: in_ready seen 1 during MAC, required 0");
        end
    endtask

    task automatic recv(input int hold);
        longint exp_v;
        logic [OUT_W-1:0] first;
        bit stable = 1'b1;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got out_data=%0d with nothing expected",
                     $signed(out_data));
            return;
        end
        exp_v = exp_q.pop_front();
        if (longint'($signed(out_data)) !== exp_v) begin
            failures++;
            $display("FAIL out_data: got %0d required %0d", $signed(out_data), exp_v);
        end
        first = out_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || out_data !== first || in_ready !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) begin
            checks++;
            if (stable !== 1'b1) begin
                failures++;
                $display("FAIL hold_stable: outputs changed while out_ready=0, required stable %0d",
                         $signed(first));
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release: got out_valid=%0b in_ready=%0b required 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic do_sample(input longint d);
        send_sample(d);
        wait_out(0);
        recv(0);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || coef_err !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: got v=%0b d=%0d err=%0b rdy=%0b required 0/0/0/1",
                     out_valid, out_data, coef_err, in_ready);
        end
    endtask

    task automatic test_identity();
        do_sample(5);
        do_sample(-7);
    endtask

    task automatic test_impulse();
        apply_reset();
        for (int i = 0; i < TAPS; i++) coef_write(i, i + 1);
        do_sample(1);
        for (int i = 0; i < TAPS; i++) do_sample(0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < TAPS; i++) coef_write(i, 127);
        for (int i = 0; i < TAPS; i++) do_sample(127);
        for (int i = 0; i < TAPS; i++) do_sample(-128);
    endtask

    task automatic test_backpressure();
        send_sample(3);
        wait_out(0);
        recv(10);
    endtask

    task automatic test_coef_busy();
        send_sample(20);
        coef_we = 1'b1;
        coef_idx = 1;
        coef_data = 8'd99;
        @(posedge clk);
        #1 coef_we = 1'b0;
        checks++;
        if (coef_err !== 1'b1) begin
            failures++;
            $display("FAIL coef_err_set: got %0b required 1", coef_err);
        end
        wait_out(1);
        recv(0);
        // Write and sample together in IDLE: write wins, sample is left unconsumed.
        coef_we = 1'b1;
        coef_idx = 2;
        coef_data = 8'hFD;
        in_valid = 1'b1;
        in_data = 8'd55;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL write_priority: in_ready=%0b required 0", in_ready);
        end
        @(posedge clk);
        #1 coef_we = 1'b0;
        in_valid = 1'b0;
        mc[2] = -3;
        begin
            bit idle_ok = 1'b1;
            for (int i = 0; i < TAPS + 2; i++) begin
                @(posedge clk);
                #1;
                if (out_valid !== 1'b0 || in_ready !== 1'b1) idle_ok = 1'b0;
            end
            checks++;
            if (idle_ok !== 1'b1) begin
                failures++;
                $display("FAIL sample_consumed: core left IDLE, required to stay idle");
            end
        end
        do_sample(2);
        checks++;
        if (coef_err !== 1'b1) begin
            failures++;
            $display("FAIL coef_err_sticky: got %0b required 1", coef_err);
        end
    endtask

    task automatic test_reset_mid_mac();
        send_sample(33);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || coef_err !== 1'b0 || out_data !== '0) begin
            failures++;
            $display("FAIL async_reset: got v=%0b err=%0b d=%0d required 0/0/0",
                     out_valid, coef_err, out_data);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        do_sample(9);
        do_sample(4);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < TAPS; i++) coef_write(i, $signed(8'($urandom_range(0, 255))));
        for (int i = 0; i < 6; i++) do_sample($signed(8'($urandom_range(0, 255))));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_identity();
        test_impulse();
        test_saturation();
        test_backpressure();
        test_coef_busy();
        test_reset_mid_mac();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: got %0d pending required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
